// File: rtl/gcd_engine.sv
// gcd_engine
//   Sequential greatest-common-divisor engine using a subtract-and-compare
//   datapath and a three-state controller (IDLE, CMP, DONE) with a
//   start/done handshake.
//
//   Optional build macro: GCD_ITER_CNT_EN
//     When defined, the engine exposes iter_count, a saturating count of the
//     subtractions performed by the most recent operation.
//
// Ports
//   clk        in   1      rising-edge clock
//   reset      in   1      synchronous, active-high reset
//   start      in   1      request, sampled only in IDLE
//   a_in       in   WIDTH  operand A, captured on the start-accepting edge
//   b_in       in   WIDTH  operand B, captured on the start-accepting edge
//   busy       out  1      high while computing (CMP)
//   done       out  1      one-cycle completion pulse (DONE)
//   result     out  WIDTH  last GCD, held until the next completion
//   iter_count out  WIDTH  subtraction count (GCD_ITER_CNT_EN only)
module gcd_engine #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
`ifdef GCD_ITER_CNT_EN
    ,
    output logic [WIDTH-1:0] iter_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ZERO = '0;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] rb_q, rb_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             terminal;
    logic             subtract;

    // Equal registers or a zero register end the loop; OR-ing the two then
    // gives the shared value or the nonzero one (and 0 for gcd(0,0)).
    assign terminal = (ra_q == rb_q) || (ra_q == ZERO) || (rb_q == ZERO);
    assign subtract = (state_q == S_CMP) && !terminal;

    always_comb begin
        state_d  = state_q;
        ra_d     = ra_q;
        rb_d     = rb_q;
        result_d = result_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    ra_d    = a_in;
                    rb_d    = b_in;
                    state_d = S_CMP;
                end
            end
            S_CMP: begin
                if (terminal) begin
                    result_d = ra_q | rb_q;
                    state_d  = S_DONE;
                end else if (ra_q > rb_q) begin
                    // Larger register is always the minuend, so no borrow.
                    ra_d = ra_q - rb_q;
                end else begin
                    rb_d = rb_q - ra_q;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Status outputs are registered copies of the next state.
        busy_d = (state_d == S_CMP);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            ra_q     <= '0;
            rb_q     <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ra_q     <= ra_d;
            rb_q     <= rb_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

`ifdef GCD_ITER_CNT_EN
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] iter_count_q, iter_count_d;

    // Cleared when an operation is accepted, saturating increment per
    // subtraction, otherwise held so the final count stays readable.
    always_comb begin
        iter_count_d = iter_count_q;
        if (state_q == S_IDLE && start) begin
            iter_count_d = '0;
        end else if (subtract && iter_count_q != '1) begin
            iter_count_d = iter_count_q + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            iter_count_q <= '0;
        end else begin
            iter_count_q <= iter_count_d;
        end
    end

    assign iter_count = iter_count_q;
`else
    // No subtraction counter in this build; subtract only steers the datapath.
    logic unused_subtract;
    assign unused_subtract = subtract;
`endif

endmodule

// File: tb/tb_gcd_engine.sv
// Directed testbench for gcd_engine (WIDTH=8). Expected results, subtraction
// counts and completion edges are hand-computed per vector.
module tb_gcd_engine;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic       busy;
    logic       done;
    logic [7:0] result;
`ifdef GCD_ITER_CNT_EN
    logic [7:0] iter_count;
`endif

    int checks;
    int failures;

    gcd_engine #(.WIDTH(8)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .a_in   (a_in),
        .b_in   (b_in),
        .busy   (busy),
        .done   (done),
        .result (result)
`ifdef GCD_ITER_CNT_EN
        ,
        .iter_count (iter_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete operation: start sampled on edge 1, done expected after
    // edge n+2 with result exp_r and n subtractions.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input int exp_r, input int n);
        int bad;
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        a_in  = 8'hA5;
        b_in  = 8'h5A;
        check_eq({tag, "_busy_e1"}, int'(busy), 1);
        bad = 0;
        for (int e = 2; e <= n + 2; e++) begin
            tick();
            if (e < n + 2 && (busy !== 1'b1 || done !== 1'b0)) bad++;
        end
        check_eq({tag, "_busy_hold"}, bad, 0);
        check_eq({tag, "_done"}, int'(done), 1);
        check_eq({tag, "_busy_end"}, int'(busy), 0);
        check_eq({tag, "_result"}, int'(result), exp_r);
`ifdef GCD_ITER_CNT_EN
        check_eq({tag, "_iter"}, int'(iter_count), n);
`endif
        tick();
        check_eq({tag, "_done_pulse"}, int'(done), 0);
        check_eq({tag, "_result_hold"}, int'(result), exp_r);
`ifdef GCD_ITER_CNT_EN
        check_eq({tag, "_iter_hold"}, int'(iter_count), n);
`endif
    endtask

    initial begin
        int bad;
        logic exp_done;
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        start    = 1'b0;
        a_in     = '0;
        b_in     = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check_eq("rst_result", int'(result), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_done", int'(done), 0);
`ifdef GCD_ITER_CNT_EN
        check_eq("rst_iter", int'(iter_count), 0);
`endif

        // 12,8 -> 4,8 -> 4,4 : N=2, gcd 4
        run_op("g12_8", 8'd12, 8'd8, 4, 2);

        // Reset on edge 3 of a 12/8 operation discards it.
        a_in  = 8'd12;
        b_in  = 8'd8;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("midrst_busy", int'(busy), 0);
        check_eq("midrst_done", int'(done), 0);
        check_eq("midrst_result", int'(result), 0);
`ifdef GCD_ITER_CNT_EN
        check_eq("midrst_iter", int'(iter_count), 0);
`endif
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0 || result !== 8'd0) bad++;
        end
        check_eq("midrst_quiet", bad, 0);

        run_op("g0_9", 8'd0, 8'd9, 9, 0);
        run_op("g0_0", 8'd0, 8'd0, 0, 0);
        run_op("g255_1", 8'd255, 8'd1, 1, 254);

        // 48,18 -> 30,18 -> 12,18 -> 12,6 -> 6,6 : N=4, done after edge 6.
        a_in  = 8'd48;
        b_in  = 8'd18;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        a_in  = 8'd7;
        b_in  = 8'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check_eq("ign_done_e5", int'(done), 0);
        tick();
        check_eq("ign_done_e6", int'(done), 1);
        check_eq("ign_result", int'(result), 6);
`ifdef GCD_ITER_CNT_EN
        check_eq("ign_iter", int'(iter_count), 4);
`endif
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("ign_busy_e7", int'(busy), 0);
        check_eq("ign_done_e7", int'(done), 0);
        tick();
        check_eq("ign_busy_e8", int'(busy), 0);
        check_eq("ign_result_e8", int'(result), 6);

        // Held start, 9,6 -> 3,6 -> 3,3 : N=2, done after edges 4, 9, 14.
        a_in  = 8'd9;
        b_in  = 8'd6;
        start = 1'b1;
        for (int e = 1; e <= 14; e++) begin
            tick();
            exp_done = (e == 4) || (e == 9) || (e == 14);
            check_eq($sformatf("held_done_e%0d", e), int'(done), int'(exp_done));
            if (exp_done) check_eq($sformatf("held_result_e%0d", e), int'(result), 3);
        end
        start = 1'b0;
        tick();
        tick();
        check_eq("held_idle_busy", int'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
